// File: rtl/alu_issue_if.sv
// Upstream op handshake into the ALU issue stage.
// The producer side uses the master modport and the issue stage uses the slave modport.
interface alu_issue_if #(
  parameter int XLEN = 64,
  parameter int RW   = 5
);
  logic            op_valid;
  logic            op_ready;
  logic [4:0]      op_code;
  logic [RW-1:0]   op_rd;
  logic [RW-1:0]   op_rs1;
  logic [RW-1:0]   op_rs2;
  logic            op_imm_sel;
  logic [XLEN-1:0] op_imm;

  modport master (
    output op_valid, op_code, op_rd, op_rs1, op_rs2, op_imm_sel, op_imm,
    input  op_ready
  );

  modport slave (
    input  op_valid, op_code, op_rd, op_rs1, op_rs2, op_imm_sel, op_imm,
    output op_ready
  );
endinterface

// File: rtl/alu_issue.sv
// Issue stage for a 64-bit ALU with a one-cycle registered result.
// Buffers ops, reads and forwards operands, interlocks on EX hazards and writes results back.
module alu_issue #(
  parameter  int XLEN       = 64,
  parameter  int NREGS      = 32,
  localparam int RW         = $clog2(NREGS),
  parameter  int FIFO_DEPTH = 2,
  parameter  int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_issue_if.slave       up,
  input  logic             hold,
  output logic [4:0]       alu_instruction,
  output logic [XLEN-1:0]  alu_a,
  output logic [XLEN-1:0]  alu_b,
  input  logic [XLEN-1:0]  alu_l1r,
  output logic [CNT_W-1:0] illegal_cnt,
  input  logic [RW-1:0]    dbg_addr,
  output logic [XLEN-1:0]  dbg_data
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [4:0] BUBBLE = 5'd31;

  typedef struct packed {
    logic [4:0]      code;
    logic [RW-1:0]   rd;
    logic [RW-1:0]   rs1;
    logic [RW-1:0]   rs2;
    logic            imm_sel;
    logic [XLEN-1:0] imm;
  } op_t;

  op_t             fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count, count_next;
  logic [XLEN-1:0] rf [NREGS];

  logic            ex_valid, wb_valid;
  logic [RW-1:0]   ex_rd, wb_rd;

  op_t             in_op, head;
  logic            head_valid, head_illegal, raw, issue, drop, push, pop;
  logic [XLEN-1:0] src_a, src_b;

  // Register 0 reads as zero; the op leaving WB is forwarded ahead of the file.
  function automatic logic [XLEN-1:0] read_src(input logic [RW-1:0] idx);
    if (idx == '0) return '0;
    if (wb_valid && wb_rd == idx) return alu_l1r;
    return rf[idx];
  endfunction

  // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
  always_comb begin
    in_op        = '{code: up.op_code, rd: up.op_rd, rs1: up.op_rs1, rs2: up.op_rs2,
                     imm_sel: up.op_imm_sel, imm: up.op_imm};
    head         = fifo_mem[rd_ptr];
    head_valid   = (count != '0);
    head_illegal = (head.code > 5'd4);
    raw          = ex_valid && (ex_rd != '0) &&
                   ((head.rs1 == ex_rd) || (!head.imm_sel && head.rs2 == ex_rd));
    drop         = head_valid && !hold && head_illegal;
    issue        = head_valid && !hold && !head_illegal && !raw;
    pop          = issue || drop;
    push         = up.op_valid && up.op_ready;
    src_a        = read_src(head.rs1);
    src_b        = head.imm_sel ? head.imm : read_src(head.rs2);
    count_next   = count;
    if (push && !pop)      count_next = count + CW'(1);
    else if (pop && !push) count_next = count - CW'(1);
  end

  // NOTE: the FIFO storage is not reset; count alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= in_op;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      up.op_ready <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count       <= count_next;
      up.op_ready <= (count_next != CW'(FIFO_DEPTH));
    end
  end

  // EX stage drives the ALU; WB tracks the op whose result is on alu_l1r.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid        <= 1'b0;
      ex_rd           <= '0;
      wb_valid        <= 1'b0;
      wb_rd           <= '0;
      alu_instruction <= BUBBLE;
      alu_a           <= '0;
      alu_b           <= '0;
      illegal_cnt     <= '0;
    end else begin
      wb_valid <= ex_valid;
      wb_rd    <= ex_rd;
      if (issue) begin
        ex_valid        <= 1'b1;
        ex_rd           <= head.rd;
        alu_instruction <= head.code;
        alu_a           <= src_a;
        alu_b           <= src_b;
      end else begin
        ex_valid        <= 1'b0;
        alu_instruction <= BUBBLE;
      end
      if (drop && illegal_cnt != '1) illegal_cnt <= illegal_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (wb_valid && wb_rd != '0) begin
      rf[wb_rd] <= alu_l1r;
    end
  end

  assign dbg_data = (dbg_addr == '0) ? '0 : rf[dbg_addr];
endmodule
